// File: rtl/hazard_pkg.sv
// Shared decode constants, forwarding encodings, stall FSM states and
// instruction field helpers for the hazard/forwarding controller.
package hazard_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_MW   = 2'b01;
  localparam logic [1:0] FWD_XM   = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_LU, ST_MD_WAIT} stall_st_e;

  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] aluop;
  } insn_f_t;

  function automatic insn_f_t insn_fields(input logic [31:0] insn);
    insn_f_t f;
    f.opcode = insn[31:27];
    f.rd     = insn[26:22];
    f.rs     = insn[21:17];
    f.rt     = insn[16:12];
    f.aluop  = insn[6:2];
    return f;
  endfunction

  function automatic logic [4:0] insn_rd(input logic [31:0] insn);
    insn_f_t f = insn_fields(insn);
    return f.rd;
  endfunction

  function automatic logic [4:0] insn_src_a(input logic [31:0] insn);
    insn_f_t f = insn_fields(insn);
    return f.rs;
  endfunction

  // Stores and branches read their second operand from the rd slot; opcodes
  // without a second register operand report r0 so they never hazard.
  function automatic logic [4:0] insn_src_b(input logic [31:0] insn);
    insn_f_t f = insn_fields(insn);
    case (f.opcode)
      OP_RTYPE:                    return f.rt;
      OP_SW, OP_BNE, OP_BLT, OP_JR: return f.rd;
      default:                     return 5'd0;
    endcase
  endfunction

  function automatic logic insn_is_lw(input logic [31:0] insn);
    insn_f_t f = insn_fields(insn);
    return f.opcode == OP_LW;
  endfunction

  function automatic logic insn_is_sw(input logic [31:0] insn);
    insn_f_t f = insn_fields(insn);
    return f.opcode == OP_SW;
  endfunction

  function automatic logic insn_is_md(input logic [31:0] insn);
    insn_f_t f = insn_fields(insn);
    return (f.opcode == OP_RTYPE) && ((f.aluop == ALU_MUL) || (f.aluop == ALU_DIV));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic xm_v, input logic [4:0] xm_rd,
                                         input logic mw_v, input logic [4:0] mw_rd);
    if (src == 5'd0)              return FWD_RF;
    if (xm_v && (xm_rd == src))   return FWD_XM;
    if (mw_v && (mw_rd == src))   return FWD_MW;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-latch side bundle of the hazard/forwarding controller.
interface hazard_forward_unit_if #(parameter int INSN_W = 32);
  logic [INSN_W-1:0] fd_insn;
  logic [INSN_W-1:0] dx_insn;
  logic [INSN_W-1:0] xm_insn;
  logic [INSN_W-1:0] mw_insn;
  logic              xm_we;
  logic              mw_we;
  logic              md_done;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              fwd_dmem;
  logic              stall_fd;
  logic              flush_dx;
  logic              md_busy;
  logic [31:0]       perf_lu_cnt;
  logic [31:0]       perf_md_cnt;

  modport master (
    output fd_insn, dx_insn, xm_insn, mw_insn, xm_we, mw_we, md_done,
    input  fwd_a, fwd_b, fwd_dmem, stall_fd, flush_dx, md_busy, perf_lu_cnt, perf_md_cnt
  );

  modport slave (
    input  fd_insn, dx_insn, xm_insn, mw_insn, xm_we, mw_we, md_done,
    output fwd_a, fwd_b, fwd_dmem, stall_fd, flush_dx, md_busy, perf_lu_cnt, perf_md_cnt
  );
endinterface

// File: rtl/md_scoreboard.sv
// In-order FIFO of outstanding mul/div destinations plus a per-register pending mask.
module md_scoreboard #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [AW-1:0]     push_rd_i,
  input  logic              pop_i,
  output logic [2**AW-1:0]  pending_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]              cnt_q, cnt_d, widx;
  logic [DEPTH-1:0][AW-1:0]   ent_q, ent_d;
  logic [2**AW-1:0]           mask_q, mask_d;
  logic                       pop, push, younger;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign pending_o = mask_q;

  // Entry 0 is always the oldest; a pop shifts the queue down.
  always_comb begin
    pop     = pop_i && !empty_o;
    push    = push_i && (!full_o || pop);
    younger = 1'b0;
    for (int i = 1; i < DEPTH; i++)
      if ((CW'(i) < cnt_q) && (ent_q[i] == ent_q[0])) younger = 1'b1;

    ent_d  = ent_q;
    mask_d = mask_q;
    widx   = cnt_q - CW'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      if (!younger) mask_d[ent_q[0]] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == widx) ent_d[i] = push_rd_i;
      mask_d[push_rd_i] = 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      ent_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ent_q  <= ent_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// Operand bypass selects, load-use and mul/div stalls for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the saturating stall counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int INSN_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MD_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);
  localparam int NREG = 1 << REG_AW;

  logic [4:0]      fd_src_a, fd_src_b, dx_rd, dx_src_a, dx_src_b, xm_rd, mw_rd;
  logic            fd_md, dx_lw, dx_md, xm_sw, xm_md;
  logic            xm_src, mw_src, lu_haz, md_haz, stall, push;
  logic            sb_full, sb_empty;
  logic [NREG-1:0] pending;
  stall_st_e       state_q;

  assign fd_src_a = insn_src_a(bus.fd_insn[31:0]);
  assign fd_src_b = insn_src_b(bus.fd_insn[31:0]);
  assign fd_md    = insn_is_md(bus.fd_insn[31:0]);
  assign dx_rd    = insn_rd(bus.dx_insn[31:0]);
  assign dx_src_a = insn_src_a(bus.dx_insn[31:0]);
  assign dx_src_b = insn_src_b(bus.dx_insn[31:0]);
  assign dx_lw    = insn_is_lw(bus.dx_insn[31:0]);
  assign dx_md    = insn_is_md(bus.dx_insn[31:0]);
  assign xm_rd    = insn_rd(bus.xm_insn[31:0]);
  assign xm_sw    = insn_is_sw(bus.xm_insn[31:0]);
  assign xm_md    = insn_is_md(bus.xm_insn[31:0]);
  assign mw_rd    = insn_rd(bus.mw_insn[31:0]);

  // A mul/div sitting in X/M has no result yet, so it is never a bypass source.
  assign xm_src = bus.xm_we && !xm_md && (xm_rd != 5'd0);
  assign mw_src = bus.mw_we && (mw_rd != 5'd0);

  assign bus.fwd_a    = fwd_sel(dx_src_a, xm_src, xm_rd, mw_src, mw_rd);
  assign bus.fwd_b    = fwd_sel(dx_src_b, xm_src, xm_rd, mw_src, mw_rd);
  assign bus.fwd_dmem = xm_sw && bus.mw_we && (xm_rd != 5'd0) && (mw_rd == xm_rd);

  assign lu_haz = dx_lw && (dx_rd != 5'd0) && ((dx_rd == fd_src_a) || (dx_rd == fd_src_b));
  assign md_haz = ((fd_src_a != 5'd0) && pending[fd_src_a]) ||
                  ((fd_src_b != 5'd0) && pending[fd_src_b]) ||
                  (fd_md && sb_full && !bus.md_done);

  // In LU the load has already moved past D/X, so the bubble lasts one cycle.
  assign stall        = md_haz || (lu_haz && (state_q != ST_LU));
  assign bus.stall_fd = stall;
  assign bus.flush_dx = stall;
  assign bus.md_busy  = !sb_empty;
  assign push         = dx_md && (dx_rd != 5'd0) && !stall;

  md_scoreboard #(.DEPTH(MD_DEPTH), .AW(REG_AW)) u_sb (
    .clk_i     (clock),
    .rst_i     (reset),
    .push_i    (push),
    .push_rd_i (dx_rd),
    .pop_i     (bus.md_done),
    .pending_o (pending),
    .full_o    (sb_full),
    .empty_o   (sb_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:     if (md_haz) state_q <= ST_MD_WAIT;
                    else if (lu_haz) state_q <= ST_LU;
        ST_LU:      state_q <= ST_RUN;
        ST_MD_WAIT: if (!md_haz) state_q <= ST_RUN;
        default:    state_q <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d, md_cnt_q, md_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    md_cnt_d = md_cnt_q;
    if ((state_q == ST_LU) && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 32'd1;
    if (md_haz && (md_cnt_q != '1))             md_cnt_d = md_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign bus.perf_lu_cnt = lu_cnt_q;
  assign bus.perf_md_cnt = md_cnt_q;
`else
  assign bus.perf_lu_cnt = '0;
  assign bus.perf_md_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed vectors for hazard_forward_unit; expectations are queued and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_forward_unit;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.INSN_W(32)) bus();

  hazard_forward_unit #(.INSN_W(32), .REG_AW(5), .MD_DEPTH(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        dm;
    logic        st;
    logic        busy;
    bit          pchk;
    logic [31:0] plu;
    logic [31:0] pmd;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  logic chk_vld = 1'b0;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] ins(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, rs, rt);
    return ins(OP_RTYPE, rd, rs, rt, 5'd0);
  endfunction
  function automatic logic [31:0] mul(input logic [4:0] rd, rs, rt);
    return ins(OP_RTYPE, rd, rs, rt, ALU_MUL);
  endfunction
  function automatic logic [31:0] div(input logic [4:0] rd, rs, rt);
    return ins(OP_RTYPE, rd, rs, rt, ALU_DIV);
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs);
    return ins(OP_LW, rd, rs, 5'd0, 5'd0);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rd, rs);
    return ins(OP_SW, rd, rs, 5'd0, 5'd0);
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: DUT output sampled with no queued expectation");
      end else begin
        me = exp_q.pop_front();
        cmp(me.nm, "fwd_a",    32'(bus.fwd_a),    32'(me.fa));
        cmp(me.nm, "fwd_b",    32'(bus.fwd_b),    32'(me.fb));
        cmp(me.nm, "fwd_dmem", 32'(bus.fwd_dmem), 32'(me.dm));
        cmp(me.nm, "stall_fd", 32'(bus.stall_fd), 32'(me.st));
        cmp(me.nm, "flush_dx", 32'(bus.flush_dx), 32'(me.st));
        cmp(me.nm, "md_busy",  32'(bus.md_busy),  32'(me.busy));
        if (me.pchk) begin
          cmp(me.nm, "perf_lu", bus.perf_lu_cnt, me.plu);
          cmp(me.nm, "perf_md", bus.perf_md_cnt, me.pmd);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [31:0] fd, dx, xm, mw,
                      input logic xw, mww, md, r,
                      input logic [1:0] fa, fb, input logic dm, st, busy,
                      input bit pchk = 1'b0, input logic [31:0] plu = 32'd0, input logic [31:0] pmd = 32'd0);
    exp_t e;
    @(posedge clk);
    #1;
    bus.fd_insn = fd;
    bus.dx_insn = dx;
    bus.xm_insn = xm;
    bus.mw_insn = mw;
    bus.xm_we   = xw;
    bus.mw_we   = mww;
    bus.md_done = md;
    rst         = r;
    e.nm = nm; e.fa = fa; e.fb = fb; e.dm = dm; e.st = st; e.busy = busy;
    e.pchk = pchk; e.plu = plu; e.pmd = pmd;
    exp_q.push_back(e);
    chk_vld = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.fd_insn = NOP; bus.dx_insn = NOP; bus.xm_insn = NOP; bus.mw_insn = NOP;
    bus.xm_we = 1'b0; bus.mw_we = 1'b0; bus.md_done = 1'b0;

    //    name          fd            dx            xm            mw            xw mw md r   fa fb dm st busy
    step("reset",       NOP,          NOP,          NOP,          NOP,          0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0);
    step("fwd_xm",      NOP,          add(3,1,2),   add(1,0,0),   add(1,0,0),   1, 1, 0, 0,  2, 0, 0, 0, 0);
    step("fwd_mw",      NOP,          add(3,1,2),   add(5,0,0),   add(1,0,0),   1, 1, 0, 0,  1, 0, 0, 0, 0);
    step("fwd_b_xm",    NOP,          add(3,1,2),   add(2,0,0),   add(1,0,0),   1, 1, 0, 0,  1, 2, 0, 0, 0);
    step("we_off",      NOP,          add(3,1,2),   add(1,0,0),   add(1,0,0),   0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("r0_never",    NOP,          add(3,0,0),   add(0,0,0),   add(0,0,0),   1, 1, 0, 0,  0, 0, 0, 0, 0);
    step("md_xm_nofwd", NOP,          add(3,1,2),   mul(1,9,9),   add(1,0,0),   1, 1, 0, 0,  1, 0, 0, 0, 0);
    step("fwd_dmem",    NOP,          NOP,          sw(4,1),      add(4,0,0),   0, 1, 0, 0,  0, 0, 1, 0, 0);
    step("dmem_we0",    NOP,          NOP,          sw(4,1),      add(4,0,0),   0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("lu_hit",      add(6,4,2),   lw(4,1),      NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 0);
    step("lu_bubble",   add(6,4,2),   NOP,          lw(4,1),      NOP,          1, 0, 0, 0,  0, 0, 0, 0, 0);
    step("lu_fwd_mw",   NOP,          add(6,4,2),   NOP,          lw(4,1),      0, 1, 0, 0,  1, 0, 0, 0, 0);
    step("lu2_rt",      add(7,1,5),   lw(5,0),      NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 0);
    step("lu2_bubble",  add(7,1,5),   NOP,          lw(5,0),      NOP,          1, 0, 0, 0,  0, 0, 0, 0, 0);
    step("lu3_sw_rd",   sw(9,2),      lw(9,3),      NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 0);
    step("lu3_bubble",  sw(9,2),      NOP,          lw(9,3),      NOP,          1, 0, 0, 0,  0, 0, 0, 0, 0);
    step("lu_r0",       add(1,0,0),   lw(0,3),      NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("md_push_mul", NOP,          mul(7,1,2),   NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("md_push_div", NOP,          div(8,1,2),   NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("md_wait",     add(9,8,0),   NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 1);
    step("md_pop1",     add(9,8,0),   NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 1, 1);
    step("md_pop2",     add(9,8,0),   NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 1, 1);
    step("md_clear",    add(9,8,0),   NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("fill1",       NOP,          mul(10,1,2),  NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("fill2",       NOP,          mul(11,1,2),  NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("full_stall",  mul(12,1,2),  NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 1);
    step("full_pop",    mul(12,1,2),  NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 0, 1);
    step("push_pop",    NOP,          mul(12,1,2),  NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 0, 1);
    step("pop_last",    NOP,          NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 0, 1);
    step("empty",       NOP,          NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("same1",       NOP,          mul(13,1,2),  NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("same2",       NOP,          mul(13,1,2),  NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 1);
    step("same_pop1",   add(1,13,0),  NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 1, 1);
    step("same_hold",   add(1,13,0),  NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 1);
    step("same_pop2",   add(1,13,0),  NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 1, 1);
    step("same_clear",  add(1,13,0),  NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("rst_fill",    NOP,          mul(14,1,2),  NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);
    step("rst_wait",    add(1,14,0),  NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 1, 1);
    step("rst_assert",  add(1,14,0),  NOP,          NOP,          NOP,          0, 0, 0, 1,  0, 0, 0, 1, 1,
         1, PERF ? 32'd3 : 32'd0, PERF ? 32'd8 : 32'd0);
    step("rst_cleared", add(1,14,0),  NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0);
    step("rst_done_ign",add(1,14,0),  NOP,          NOP,          NOP,          0, 0, 1, 0,  0, 0, 0, 0, 0);
    step("rst_idle",    add(1,14,0),  NOP,          NOP,          NOP,          0, 0, 0, 0,  0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the five-stage integer pipeline (F/D, D/X, X/M, M/W latches). It generates ALU operand bypass selects, the store-data bypass, load-use stalls and multdiv scoreboard stalls. It also tracks up to MD_DEPTH outstanding multi-cycle mul/div results. It replaces the purely combinational bypass decode with a stateful unit: a stall FSM plus an in-order scoreboard FIFO.

## Interface
- INSN_W, 32, instruction width; fields opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]
- REG_AW, 5, register address width
- MD_DEPTH, 2, max outstanding multdiv ops (1..4)
- clock  in  1  pipeline clock; all state on rising edge
- reset  in  1  synchronous, active-high
- fd_insn, dx_insn, xm_insn, mw_insn  in  INSN_W each  pipeline latch instructions
- xm_we, mw_we  in  1 each  destination write enable of X/M and M/W instruction
- md_done  in  1  multdiv unit retires oldest outstanding op this cycle
- fwd_a  out  2  ALU A select: 00 regfile, 01 M/W, 10 X/M
- fwd_b  out  2  ALU B select, same encoding
- fwd_dmem  out  1  store data in X/M taken from M/W result
- stall_fd  out  1  hold PC and F/D latch
- flush_dx  out  1  load nop into D/X latch next edge
- md_busy  out  1  scoreboard non-empty
- perf_lu_cnt, perf_md_cnt  out  32 each  stall counters (see Configuration)

## Operation
- Opcodes: R-type 00000, sw 00111, lw 01000, bne 00010, blt 00110, jr 00100; mul is R-type with aluop 00110, div is R-type with aluop 00111.
- Source A = rs. Source B is rt for R-type, and rd for sw/bne/blt/jr.
- Register 0 is never forwarded, scoreboarded or stalled on.
- Forwarding:
  - fwd_a = 10 if xm_we and xm rd == dx srcA.
  - Else fwd_a = 01 if mw_we and mw rd == dx srcA.
  - Else fwd_a = 00.
  - fwd_b uses the same rules on dx srcB. X/M always wins over M/W.
  - A mul/div in X/M is not a forwarding source; its xm_we is ignored.
- fwd_dmem = 1 when xm is sw, mw_we is set, and mw rd == xm rd (rd != 0).
- Load-use hazard:
  - Condition: dx is lw, and dx rd != 0 equals either fd source register.
  - Response: stall_fd=1 and flush_dx=1 for exactly one cycle.
- Scoreboard: in-order FIFO of MD_DEPTH destination addresses, plus a pending mask.
  - Push: dx is mul/div with rd != 0, and stall_fd is 0.
  - Pop: md_done.
  - Push and pop in the same cycle leave the count unchanged.
  - The mask bit clears on pop only if no younger entry targets the same register.
- md hazard: either of the following asserts stall_fd and flush_dx.
  - An fd source register is pending.
  - fd is mul/div while the FIFO is full and no pop occurs this cycle.
- Stall FSM states:
  - RUN: no stall.
  - LU: load-use bubble; always returns to RUN after one cycle.
  - MD_WAIT: md hazard held.
- Transitions:
  - RUN -> LU on load-use hazard.
  - RUN -> MD_WAIT on md hazard.
  - MD_WAIT -> RUN on the first edge where the md hazard is gone.
  - If both hazards occur together, MD_WAIT wins.
- Pop on an empty FIFO is ignored. Push on a full FIFO cannot occur, because it is stalled.

## Timing
- fwd_a, fwd_b, fwd_dmem: combinational from the current latch inputs, zero latency.
- stall_fd and flush_dx: combinational from the FSM state, the fd/dx decode and the scoreboard.
- Scoreboard and FSM update on the rising edge.
- A pop at edge N clears stall_fd in cycle N+1. The waiting instruction reads the value through M/W forwarding or the regfile.
- Reset (synchronous):
  - FSM = RUN, FIFO empty, mask 0, counters 0, md_busy = 0.
  - Combinational outputs follow the inputs. stall_fd = flush_dx = 0 while the FIFO is empty and no load-use hazard exists.
- Reset mid-MD_WAIT discards all outstanding entries. Subsequent md_done pulses are ignored until the next push.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_lu_cnt counts cycles in LU.
  - perf_md_cnt counts cycles with the md hazard stall asserted.
  - Both are 32-bit, saturating at 0xFFFFFFFF, and cleared by reset.
- Undefined: both ports are driven 0 and no counter flops are inferred.

## Structure
- Package hazard_pkg holds:
  - opcode and aluop constants
  - fwd select encodings (FWD_RF, FWD_MW, FWD_XM)
  - FSM state enum
  - an insn field-extraction function
- Sub-module md_scoreboard holds the FIFO, pending mask, push/pop and full/empty logic. The top-level module contains decode, forwarding, FSM and counters.

## Test plan
- dx add r3,r1,r2; xm add r1 (we=1); mw add r1 (we=1) -> fwd_a=10, fwd_b=00. Change xm rd to r5 -> fwd_a=01.
- xm/mw writing r0 with we=1, dx reads r0 -> fwd_a=fwd_b=00, no stall.
- dx lw r4; fd add r6,r4,r2 -> stall_fd=flush_dx=1 for one cycle. Next cycle 0, with fwd_a=01 once lw reaches M/W.
- MD_DEPTH=2: mul r7, then div r8 issued; fd reads r8. Stall persists through the first md_done and clears the cycle after the second md_done. fd mul issued while full -> stalled until a pop.
- md_done and a new mul push in the same cycle with the FIFO at 1 -> md_busy stays 1, count stays 1. Reset asserted mid-MD_WAIT -> next cycle stall_fd=0, md_busy=0.
- With HAZARD_PERF_EN: three load-use events -> perf_lu_cnt=3. Without the macro, both counters read 0.
